// File: rtl/arm_sc_pkg.sv
// Shared types and constants for the single-cycle ARM instruction-fetch front end.
package arm_sc_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_VALID = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory req/ready bus between the fetch unit (master) and memory (slave).
interface fetch_unit_if;
    import arm_sc_pkg::*;

    logic [ADDR_W-1:0]  IAddr;
    logic               IReq;
    logic [INSTR_W-1:0] IRdata;
    logic               IReady;

    modport master (
        output IAddr,
        output IReq,
        input  IRdata,
        input  IReady
    );

    modport slave (
        input  IAddr,
        input  IReq,
        output IRdata,
        output IReady
    );

endinterface

// File: rtl/fetch_unit_pc_register.sv
// Program counter with next-PC selection and the PC+4 / PC+8 adders.
module pc_register
    import arm_sc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              i_load,
    input  logic              i_pcSrc,
    input  logic [ADDR_W-1:0] i_result,
    output logic [ADDR_W-1:0] o_pc,
    output logic [ADDR_W-1:0] o_pcPlus4,
    output logic [ADDR_W-1:0] o_pcPlus8
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_nextPc;

    assign o_pc      = r_pc;
    assign o_pcPlus4 = r_pc + ADDR_W'(4);
    assign o_pcPlus8 = r_pc + ADDR_W'(8);

    // Branch targets are forced onto a word boundary; the low result bits are dropped.
    assign w_nextPc = i_pcSrc ? (i_result & ~ADDR_W'(3)) : o_pcPlus4;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_pc <= RESET_VECTOR;
        end else if (i_load) begin
            r_pc <= w_nextPc;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over req/ready, presents a held Instr.
// Optional per-fetch timeout with sticky FetchErr is enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
    import arm_sc_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR   = DEFAULT_RESET_VECTOR,
    parameter int                CNT_W          = 16,
    parameter int                TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               PCSrc,
    input  logic [ADDR_W-1:0]  Result,
    input  logic               Advance,
    fetch_unit_if.master       imem,
    output logic [INSTR_W-1:0] Instr,
    output logic               InstrValid,
    output logic [ADDR_W-1:0]  PC,
    output logic [ADDR_W-1:0]  PCPlus4,
    output logic [ADDR_W-1:0]  PCPlus8,
    output logic [CNT_W-1:0]   StallCnt,
    output logic               FetchErr
);

    fetch_state_t       r_state;
    logic               r_iReq;
    logic               r_instrValid;
    logic [INSTR_W-1:0] r_instr;
    logic [CNT_W-1:0]   r_stallCnt;
    logic               w_pcLoad;
    logic               w_timeout;

    assign w_pcLoad = (r_state == S_VALID) && Advance;

    pc_register #(
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pcRegister (
        .clk       (clk),
        .Reset     (Reset),
        .i_load    (w_pcLoad),
        .i_pcSrc   (PCSrc),
        .i_result  (Result),
        .o_pc      (PC),
        .o_pcPlus4 (PCPlus4),
        .o_pcPlus8 (PCPlus8)
    );

`ifdef FETCH_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [WAIT_W-1:0] r_waitCnt;
    logic              r_fetchErr;

    // Fires on the wait cycle that brings the count of unanswered cycles to TIMEOUT_CYCLES.
    assign w_timeout = (r_waitCnt == WAIT_W'(TIMEOUT_CYCLES - 1));
    assign FetchErr  = r_fetchErr;

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_waitCnt  <= '0;
            r_fetchErr <= 1'b0;
        end else if ((r_state == S_REQ) && !imem.IReady) begin
            if (w_timeout) begin
                r_waitCnt  <= '0;
                r_fetchErr <= 1'b1;
            end else begin
                r_waitCnt <= r_waitCnt + 1'b1;
            end
        end else begin
            r_waitCnt <= '0;
        end
    end
`else
    assign w_timeout = 1'b0;
    assign FetchErr  = 1'b0;
`endif

    assign imem.IAddr = PC;
    assign imem.IReq  = r_iReq;
    assign Instr      = r_instr;
    assign InstrValid = r_instrValid;
    assign StallCnt   = r_stallCnt;

    // IReq and InstrValid are registered so an asynchronous reset drops them immediately.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_iReq       <= 1'b0;
            r_instrValid <= 1'b0;
            r_instr      <= '0;
            r_stallCnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_iReq  <= 1'b1;
                end
                S_REQ: begin
                    if (imem.IReady) begin
                        r_instr      <= imem.IRdata;
                        r_instrValid <= 1'b1;
                        r_iReq       <= 1'b0;
                        r_state      <= S_VALID;
                    end else begin
                        if (r_stallCnt != '1) begin
                            r_stallCnt <= r_stallCnt + 1'b1;
                        end
                        if (w_timeout) begin
                            r_iReq  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_VALID: begin
                    if (Advance) begin
                        r_instrValid <= 1'b0;
                        r_iReq       <= 1'b1;
                        r_state      <= S_REQ;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_iReq       <= 1'b0;
                    r_instrValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end of the single-cycle ARM core. Sits directly upstream of the control unit and datapath.
- Owns the PC and fetches from a wait-state instruction memory over a req/ready handshake.
- Presents a held Instr[31:0] with InstrValid to the decoder/datapath.
- Consumes PCSrc and Result from the current instruction to select the next PC.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the saturating fetch-stall counter.
- TIMEOUT_CYCLES, 64, wait-cycle limit per fetch; used only with FETCH_TIMEOUT_EN.

Ports:
- clk  input  1  core clock, rising-edge.
- Reset  input  1  asynchronous, active-high reset.
- PCSrc  input  1  from control unit: 1 = next PC comes from Result (branch or write to R15).
- Result  input  32  datapath result bus; branch target when PCSrc=1.
- Advance  input  1  core has completed the presented instruction this cycle (register/memory writes commit on this edge).
- IAddr  output  32  instruction memory address, equal to PC.
- IReq  output  1  fetch request.
- IRdata  input  32  instruction memory read data.
- IReady  input  1  memory returns IRdata this cycle.
- Instr  output  32  latched instruction to the control unit and datapath.
- InstrValid  output  1  Instr is valid and stable.
- PC  output  32  address of the presented instruction.
- PCPlus4  output  32  PC+4.
- PCPlus8  output  32  PC+8, the architectural R15 read value.
- StallCnt  output  CNT_W  saturating count of cycles with IReq=1 and IReady=0.
- FetchErr  output  1  sticky fetch-timeout flag.

Behaviour:
- Reset (asynchronous, any state, mid-fetch included) forces:
  - state = S_IDLE
  - PC = RESET_VECTOR
  - Instr = 32'h0, InstrValid = 0, IReq = 0
  - StallCnt = 0, FetchErr = 0
- Any in-flight memory response is dropped. IReq and InstrValid must fall in the same cycle Reset rises.
- States:
  - S_IDLE: IReq=0. Goes to S_REQ on the next clk edge.
  - S_REQ: IReq=1. IAddr=PC, held stable until accepted. When IReq&IReady on an edge: Instr <= IRdata, InstrValid <= 1, go to S_VALID. Otherwise stay, and StallCnt increments, saturating at all-ones (no wrap).
  - S_VALID: IReq=0. Instr and PC are held while Advance=0.
- On an edge with Advance=1 in S_VALID:
  - PC <= PCSrc ? {Result[31:2],2'b00} : PCPlus4.
  - InstrValid <= 0, go to S_REQ.
- Advance is ignored outside S_VALID.
- IReady is ignored outside S_REQ, and IRdata is not sampled then.
- Minimum cost is 2 cycles per instruction: one S_REQ cycle with IReady=1, then one S_VALID cycle with Advance=1.
- PCPlus4 and PCPlus8 are combinational from PC, modulo 2^32. PC=32'hFFFF_FFFC gives PCPlus4=0 and PCPlus8=4.
- Branch targets are forced word-aligned. Result[1:0] is discarded silently.
- IAddr is driven as PC in all states. It is meaningful only when IReq=1.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Enabled:
  - A per-fetch wait counter clears on entry to S_REQ and counts IReady=0 cycles.
  - When it reaches TIMEOUT_CYCLES, FetchErr <= 1 (sticky until Reset), IReq drops, and the FSM goes to S_IDLE.
  - The fetch of the same PC is then retried from S_IDLE.
- Disabled: no wait counter; FetchErr is tied to 0; S_REQ waits indefinitely.

Decomposition:
- Package arm_sc_pkg:
  - State enum typedef (S_IDLE, S_REQ, S_VALID).
  - INSTR_W=32, ADDR_W=32.
  - Default RESET_VECTOR constant.
- Sub-module pc_register:
  - 32-bit PC flop with asynchronous active-high reset to RESET_VECTOR.
  - Load enable = state==S_VALID & Advance.
  - Next-PC mux (PCPlus4 vs aligned Result) and the +4/+8 adders.
- FSM, instruction latch, StallCnt and timeout logic stay in fetch_unit.

Test Plan:
- Reset release, IReady=1 always, Advance=1 whenever InstrValid: IAddr sequence 0, 4, 8, 12; InstrValid every second cycle; Instr equals IRdata of the prior S_REQ cycle; PCPlus8=PC+8.
- IReady low for 5 cycles in S_REQ, then high: IAddr stable throughout; StallCnt=5; Instr latched only on the ready edge.
- In S_VALID at PC=0x20, PCSrc=1, Result=0x0000_1003, Advance=1: next IAddr=0x0000_1000; at PC=0xFFFF_FFFC with PCSrc=0: next IAddr=0.
- Reset asserted mid-S_REQ with IReady=0, and separately during S_VALID with Advance=1: IReq and InstrValid go 0 immediately; PC=RESET_VECTOR; first fetch after release is RESET_VECTOR; StallCnt=0.
- CNT_W=4, IReady held low 20 cycles (macro off): StallCnt saturates at 15; FetchErr stays 0.
- FETCH_TIMEOUT_EN on, TIMEOUT_CYCLES=8, IReady low for 8 cycles: FetchErr=1 and IReq=0 for one cycle; same IAddr re-requested; FetchErr stays 1 after a successful fetch until Reset.
